// File: rtl/if_prefetch_buf.sv
// Instruction-fetch stage: single-outstanding req/ack fetcher feeding a DEPTH-entry
// {pc,insn} prefetch FIFO, with a registered decode-side output and redirect handling.
module if_prefetch_buf #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DEPTH        = 4,
  parameter int unsigned       INSN_BYTES   = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN     = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_insn_o,
  output logic              if_en_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;

  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [DATA_W-1:0] fifo_insn_q [DEPTH];

  logic              redirect, acked, pop, bypass, push;
  logic [ADDR_W-1:0] target;

  assign redirect = !stall_i && (flush_i || br_taken_i);
  assign target   = flush_i ? new_pc_i : br_addr_i;
  assign acked    = (state_q == S_REQ) && mem_ack_i;
  assign pop      = !stall_i && !redirect && (count_q != '0);
  assign bypass   = !stall_i && !redirect && (count_q == '0) && acked;
  assign push     = acked && !redirect && !bypass;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d   = state_q;
    fpc_d     = fpc_q;
    addr_d    = addr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if_pc_d   = if_pc_q;
    if_insn_d = if_insn_q;
    if_en_d   = if_en_q;

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      fpc_d   = target;
    end else if (acked) begin
      fpc_d = fpc_q + ADDR_W'(INSN_BYTES);
    end

    // The request address is captured when a request starts so DROP can keep the stale one.
    unique case (state_q)
      S_IDLE: begin
        if (!redirect && count_q < CW'(DEPTH)) begin
          state_d = S_REQ;
          addr_d  = fpc_q;
        end
      end
      S_REQ: begin
        if (mem_ack_i) begin
          if (!redirect && count_d < CW'(DEPTH)) begin
            state_d = S_REQ;
            addr_d  = fpc_d;
          end else begin
            state_d = S_IDLE;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      if_pc_d   = target;
      if_insn_d = NOP_INSN;
      if_en_d   = 1'b0;
    end else if (!stall_i) begin
      if (pop) begin
        if_pc_d   = fifo_pc_q[rptr_q];
        if_insn_d = fifo_insn_q[rptr_q];
        if_en_d   = 1'b1;
      end else if (bypass) begin
        if_pc_d   = addr_q;
        if_insn_d = mem_rdata_i;
        if_en_d   = 1'b1;
      end else begin
        if_insn_d = NOP_INSN;
        if_en_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q   <= S_IDLE;
      fpc_q     <= RESET_VECTOR;
      addr_q    <= RESET_VECTOR;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      if_pc_q   <= RESET_VECTOR;
      if_insn_q <= NOP_INSN;
      if_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      addr_q    <= addr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      if_pc_q   <= if_pc_d;
      if_insn_q <= if_insn_d;
      if_en_q   <= if_en_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      fifo_pc_q[wptr_q]   <= addr_q;
      fifo_insn_q[wptr_q] <= mem_rdata_i;
    end
  end

  assign mem_req_o  = (state_q != S_IDLE);
  assign mem_addr_o = addr_q;
  assign if_pc_o    = if_pc_q;
  assign if_insn_o  = if_insn_q;
  assign if_en_o    = if_en_q;

endmodule
